pulse_train_generator: RTL and testbench

Transmit-side counterpart to the team's edge and single-cycle-pulse detectors. On a start handshake it emits a train of `count` clean 0-1-0 pulses on `pulse`, with programmable high and low widths. Every pulse is preceded and followed by at least one low cycle. It sits on the stimulus/control side and drives a single-bit line that a pulse detector samples.

---
 rtl/pulse_train_generator_if.sv | 37 +++
 rtl/pulse_train_generator.sv | 109 ++++++++++
 tb/tb_pulse_train_generator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_generator_if.sv
// Handshake and output bundle for pulse_train_generator.
// Optional abort/aborted signals appear only when PULSE_TRAIN_ABORT_EN is defined.
interface pulse_train_generator_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic             ready;
  logic             busy;
  logic             pulse;
  logic             done;
`ifdef PULSE_TRAIN_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
    output start, count, high_len, low_len,
`ifdef PULSE_TRAIN_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  ready, busy, pulse, done
  );

  modport slave (
    input  start, count, high_len, low_len,
`ifdef PULSE_TRAIN_ABORT_EN
    input  abort,
    output aborted,
`endif
    output ready, busy, pulse, done
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Emits a train of count 0-1-0 pulses with programmable high/low widths.
// Optional abort support is enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_generator #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pulse_train_generator_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [LEN_W-1:0] r_h, w_h_nxt;
  logic [LEN_W-1:0] r_l, w_l_nxt;
  logic [LEN_W-1:0] w_h_eff, w_l_eff;
`ifdef PULSE_TRAIN_ABORT_EN
  logic             r_aborted, w_aborted_nxt;
`endif

  assign w_h_eff = (bus.high_len == '0) ? LEN_W'(1) : bus.high_len;
  assign w_l_eff = (bus.low_len  == '0) ? LEN_W'(1) : bus.low_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_rem   <= '0;
      r_h     <= '0;
      r_l     <= '0;
`ifdef PULSE_TRAIN_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rem   <= w_rem_nxt;
      r_h     <= w_h_nxt;
      r_l     <= w_l_nxt;
`ifdef PULSE_TRAIN_ABORT_EN
      r_aborted <= w_aborted_nxt;
`endif
    end
  end

  // Width counter holds cycles-left-minus-one and reloads on every HIGH/LOW entry.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_rem_nxt   = r_rem;
    w_h_nxt     = r_h;
    w_l_nxt     = r_l;
`ifdef PULSE_TRAIN_ABORT_EN
    w_aborted_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_h_nxt   = w_h_eff;
          w_l_nxt   = w_l_eff;
          w_rem_nxt = bus.count;
          if (bus.count != '0) begin
            w_state_nxt = S_HIGH;
            w_wcnt_nxt  = w_h_eff - LEN_W'(1);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_HIGH: begin
        if (r_wcnt != '0) begin
          w_wcnt_nxt = r_wcnt - LEN_W'(1);
        end else if (r_rem > CNT_W'(1)) begin
          w_state_nxt = S_LOW;
          w_rem_nxt   = r_rem - CNT_W'(1);
          w_wcnt_nxt  = r_l - LEN_W'(1);
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_LOW: begin
        if (r_wcnt != '0) begin
          w_wcnt_nxt = r_wcnt - LEN_W'(1);
        end else begin
          w_state_nxt = S_HIGH;
          w_wcnt_nxt  = r_h - LEN_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef PULSE_TRAIN_ABORT_EN
    if (((r_state == S_HIGH) || (r_state == S_LOW)) && bus.abort) begin
      w_state_nxt   = S_DONE;
      w_aborted_nxt = 1'b1;
    end
`endif
  end

  assign bus.ready = (r_state == S_IDLE);
  assign bus.busy  = (r_state == S_HIGH) || (r_state == S_LOW);
  assign bus.pulse = (r_state == S_HIGH);
  assign bus.done  = (r_state == S_DONE);
`ifdef PULSE_TRAIN_ABORT_EN
  assign bus.aborted = r_aborted;
`endif
endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pulse_train_generator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pulse_train_generator_if #(.CNT_W(8), .LEN_W(4)) bus ();

  pulse_train_generator #(.CNT_W(8), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch at a falling edge; returns at the falling edge of cycle 1 with start dropped.
  task automatic launch(input logic [7:0] n, input logic [3:0] h, input logic [3:0] l);
    bus.start    = 1'b1;
    bus.count    = n;
    bus.high_len = h;
    bus.low_len  = l;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [6:0] seq;
    logic [2:0] seq3;
    int         cyc;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    bus.high_len = '0;
    bus.low_len = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    bus.abort = 1'b0;
`endif
    tick();
    tick();
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_pulse", 32'(bus.pulse), 32'd0);
    chk("reset_done",  32'(bus.done),  32'd0);
    rst = 1'b0;
    tick();

    // Basic train, with a stray start (and different fields) in cycle 2
    launch(8'd3, 4'd1, 4'd2);
    chk("basic_busy_c1", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      seq[6-i] = bus.pulse;
      if (i == 1) begin
        bus.start = 1'b1;
        bus.count = 8'hFF;
        bus.high_len = 4'd9;
      end
      if (i == 2) bus.start = 1'b0;
      tick();
    end
    chk("basic_pulse_seq", 32'(seq), 32'b1001001);
    chk("basic_done_c8",   32'(bus.done),  32'd1);
    chk("basic_ready_c8",  32'(bus.ready), 32'd0);
    tick();
    chk("basic_ready_c9",  32'(bus.ready), 32'd1);
    chk("basic_done_c9",   32'(bus.done),  32'd0);

    // Empty train
    launch(8'd0, 4'd5, 4'd5);
    chk("empty_pulse_c1", 32'(bus.pulse), 32'd0);
    chk("empty_done_c1",  32'(bus.done),  32'd1);
    chk("empty_ready_c1", 32'(bus.ready), 32'd0);
    tick();
    chk("empty_ready_c2", 32'(bus.ready), 32'd1);
    chk("empty_pulse_c2", 32'(bus.pulse), 32'd0);

    // Zero-length clamp
    launch(8'd2, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      seq3[2-i] = bus.pulse;
      tick();
    end
    chk("clamp_pulse_seq", 32'(seq3), 32'b101);
    chk("clamp_done_c4",   32'(bus.done), 32'd1);
    tick();

    // Start held across two single-pulse trains
    bus.start = 1'b1;
    bus.count = 8'd1;
    bus.high_len = 4'd2;
    bus.low_len = 4'd1;
    tick();
    chk("held_pulse_c1", 32'(bus.pulse), 32'd1);
    tick();
    chk("held_pulse_c2", 32'(bus.pulse), 32'd1);
    tick();
    chk("held_done_c3",  32'(bus.done),  32'd1);
    chk("held_pulse_c3", 32'(bus.pulse), 32'd0);
    tick();
    chk("held_ready_c4", 32'(bus.ready), 32'd1);
    chk("held_pulse_c4", 32'(bus.pulse), 32'd0);
    tick();
    chk("held_pulse_c5", 32'(bus.pulse), 32'd1);
    tick();
    chk("held_pulse_c6", 32'(bus.pulse), 32'd1);
    tick();
    bus.start = 1'b0;
    chk("held_done_c7",  32'(bus.done),  32'd1);
    tick();
    chk("held_ready_c8", 32'(bus.ready), 32'd1);

    // Asynchronous reset in the middle of a high phase
    launch(8'd5, 4'd4, 4'd1);
    tick();
    chk("rst_pre_pulse", 32'(bus.pulse), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pulse", 32'(bus.pulse), 32'd0);
    chk("rst_async_ready", 32'(bus.ready), 32'd1);
    chk("rst_async_busy",  32'(bus.busy),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    launch(8'd1, 4'd3, 4'd1);
    for (int i = 0; i < 3; i++) begin
      seq3[2-i] = bus.pulse;
      tick();
    end
    chk("rst_after_seq",  32'(seq3), 32'b111);
    chk("rst_after_done", 32'(bus.done), 32'd1);
    tick();

`ifdef PULSE_TRAIN_ABORT_EN
    launch(8'd4, 4'd3, 4'd3);
    chk("abort_pulse_c1", 32'(bus.pulse), 32'd1);
    tick();
    chk("abort_pulse_c2", 32'(bus.pulse), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_pulse_c3",   32'(bus.pulse),   32'd0);
    chk("abort_done_c3",    32'(bus.done),    32'd1);
    chk("abort_aborted_c3", 32'(bus.aborted), 32'd1);
    tick();
    chk("abort_ready_c4",   32'(bus.ready),   32'd1);
    chk("abort_aborted_c4", 32'(bus.aborted), 32'd0);
    tick();
`endif

    // Longest train: 255*15 + 254*15 + 1 = 7636
    launch(8'd255, 4'd15, 4'd15);
    cyc = 1;
    while (!bus.done && cyc < 9000) begin
      tick();
      cyc++;
    end
    chk("max_done_cycle", 32'(cyc), 32'd7636);
    chk("max_done_seen",  32'(bus.done), 32'd1);
    tick();
    chk("max_ready_after", 32'(bus.ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
